eig_core_mc: RTL and testbench
==============================

EIG_CORE_MC -- requirements
Module: eig_core_mc

Interface
REQ-001 SHALL have parameter W, default 32: coefficient/result width, signed fixed point, even, >= 8.
REQ-002 SHALL have parameter F, default 16: fraction bits, 1 <= F <= W-2.
REQ-003 SHALL have parameter CH, default 4: channel count, power of two >= 2; CW = log2(CH).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ena  in  1  clock enable; low freezes all state and outputs.
REQ-007 in_valid  in  1  coefficient pair offered.
REQ-008 in_ready  out  1  core accepts the pair this cycle.
REQ-009 in_ch  in  CW  channel tag of the offered pair.
REQ-010 a0, a1  in  W each  signed Q(W-F).F: alpha = a0, beta = a1.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 out_ch  out  CW  channel tag of the result.
REQ-014 kappa, inv_kappa  out  W each  signed Q(W-F).F results.
REQ-015 regime  out  3  one-hot: 100 overdamped, 010 critical, 001 underdamped.
REQ-016 inv_invalid  out  1  kappa was zero; inv_kappa saturated.
REQ-017 regime_chg  out  1  regime differs from the last result on that channel.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM SHALL be IDLE -> SQUARE -> SQRT -> DIV -> OUT -> IDLE; one job in flight at a time.
REQ-020 in_ready SHALL equal (state == IDLE); a transfer is in_valid & in_ready & ena; a0, a1 and in_ch are registered on transfer.
REQ-021 SQUARE (1 cycle) SHALL form disc = a1*a1 - (a0 << (F+2)) exactly, in 2W+2 signed bits with 2F fraction bits.
REQ-022 regime SHALL be 100 if disc > 0, 010 if disc == 0, and 001 if disc < 0.
REQ-023 SQRT SHALL take exactly W+1 cycles, computing r = floor(sqrt(|disc|)) by the restoring bit-pair method.
REQ-024 kappa SHALL be r >> 1, saturated to 2^(W-1)-1 if larger.
REQ-025 DIV SHALL take exactly 2F+1 cycles of restoring division computing q = floor(2^(2F) / kappa).
REQ-026 inv_kappa SHALL be q saturated to 2^(W-1)-1; if kappa == 0, inv_kappa = 2^(W-1)-1 and inv_invalid = 1, otherwise inv_invalid = 0.
REQ-027 For a transfer in cycle T, out_valid SHALL rise in cycle T+4+W+2F, assuming ena is high throughout; default latency is 68.
REQ-028 In OUT, all result outputs SHALL hold stable until out_valid & out_ready & ena; the next cycle SHALL be IDLE, with out_valid low.
REQ-029 Result outputs SHALL otherwise retain their last values after OUT.
REQ-030 Per-channel regime table (CH x 3 bits) SHALL be written on entering OUT.
REQ-031 regime_chg SHALL equal (new regime != previous table entry).
REQ-032 ena low SHALL freeze the FSM, counters, the regime table and all outputs; latency extends by exactly the number of ena-low cycles.
REQ-033 Arithmetic SHALL be two's-complement signed throughout; no operand is truncated before saturation.

Reset
REQ-034 While rst = 1, on the clock edge the FSM SHALL enter IDLE and the regime table SHALL clear to 000.
REQ-035 Reset SHALL set out_valid, kappa, inv_kappa, regime, inv_invalid, regime_chg, out_ch to 0; busy = 0; in_ready = 1 in the first cycle after rst drops.
REQ-036 rst SHALL take priority over ena and abort any in-flight job with no output.

Verification (W=32, F=16)
REQ-037 a0=0x00010000, a1=0x00020000 -> regime 010, kappa 0, inv_kappa 0x7FFFFFFF, inv_invalid 1.
REQ-038 a0=0x00010000, a1=0x00060000 -> regime 100, kappa 0x0002D413, inv_kappa 0x00005A82, out_valid exactly 68 cycles after transfer.
REQ-039 a0=0x00050000, a1=0x00020000 -> regime 001, kappa 0x00020000, inv_kappa 0x00008000, inv_invalid 0.
REQ-040 Sequence: ch2 REQ-039 pair, then ch2 REQ-038 pair, then ch2 REQ-038 pair again, then ch1 REQ-039 pair -> regime_chg 1, 1, 0, 1.
REQ-041 out_ready low 10 cycles in OUT -> outputs stable, in_ready 0; ena low 5 cycles during DIV -> out_valid at cycle 73.
REQ-042 rst pulse during SQRT -> next cycle out_valid 0, in_ready 1; next channel-0 job reports regime_chg 1.

Source files
------------

// File: rtl/eig_core_mc.sv
// eig_core_mc: multi-channel damping-regime core. For each coefficient pair
// (alpha, beta) it forms disc = beta^2 - 4*alpha and reports the regime,
// kappa = sqrt(|disc|)/2 and inv_kappa = 1/kappa in Q(W-F).F. A single FSM
// walks one job at a time through a bit-serial square root and a
// bit-serial restoring divider.
module eig_core_mc #(
  parameter int W  = 32,
  parameter int F  = 16,
  parameter int CH = 4,
  localparam int CW = $clog2(CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ch,
  input  logic [W-1:0]  a0,
  input  logic [W-1:0]  a1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ch,
  output logic [W-1:0]  kappa,
  output logic [W-1:0]  inv_kappa,
  output logic [2:0]    regime,
  output logic          inv_invalid,
  output logic          regime_chg,
  output logic          busy
);

  localparam int DW   = 2*W + 2;           // discriminant, 2F fraction bits
  localparam int RW   = W + 1;             // square-root result
  localparam int SRW  = W + 4;             // square-root partial remainder
  localparam int QW   = 2*F + 1;           // quotient of 2^(2F) / kappa
  localparam int DRW  = W + 1;             // divider partial remainder
  localparam int MW   = (QW > W) ? QW : W; // common width for saturation
  localparam int CNTW = $clog2(2*W + 2);
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQUARE,
    S_SQRT,
    S_DIV,
    S_OUT
  } state_t;

  state_t               state;
  logic [CNTW-1:0]      cnt;

  // Job datapath registers
  logic signed [W-1:0]  a0_r;
  logic signed [W-1:0]  a1_r;
  logic [CW-1:0]        ch_r;
  logic [2:0]           reg_new;
  logic [DW-1:0]        rad;
  logic [SRW-1:0]       sq_rem;
  logic [RW-1:0]        root;
  logic [W-2:0]         kap_r;
  logic [DRW-1:0]       dv_rem;
  logic [QW-1:0]        quo;

  // Last regime reported per channel
  logic [2:0]           reg_tab [CH];

  // Combinational helpers
  logic signed [DW-1:0] a0_x;
  logic signed [DW-1:0] a1_x;
  logic signed [DW-1:0] disc;
  logic [DW-1:0]        disc_mag;
  logic [2:0]           regime_new;
  logic [SRW-1:0]       sq_acc;
  logic [SRW-1:0]       sq_trial;
  logic [SRW-1:0]       sq_rem_nxt;
  logic                 sq_ge;
  logic [RW-1:0]        root_nxt;
  logic [RW-1:0]        root_half;
  logic [W-2:0]         kap_nxt;
  logic [DRW-1:0]       kap_ext;
  logic [DRW-1:0]       dv_acc;
  logic [DRW-1:0]       dv_rem_nxt;
  logic                 dv_ge;
  logic [QW-1:0]        quo_nxt;
  logic [MW-1:0]        quo_ext;
  logic [W-1:0]         inv_nxt;

  // Exact discriminant beta^2 - 4*alpha, its magnitude and the regime it implies
  // NOTE: every variable in an always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    a0_x     = a0_r;
    a1_x     = a1_r;
    disc     = a1_x * a1_x - (a0_x <<< (F + 2));
    disc_mag = disc[DW-1] ? $unsigned(-disc) : $unsigned(disc);
    if (disc == '0)
      regime_new = 3'b010;
    else if (disc[DW-1])
      regime_new = 3'b001;
    else
      regime_new = 3'b100;
  end

  // One restoring square-root step: bring down two radicand bits, try 4*root+1
  always_comb begin
    sq_acc     = (sq_rem << 2) | SRW'(rad[DW-1 -: 2]);
    sq_trial   = (SRW'(root) << 2) | SRW'(2'b01);
    sq_ge      = (sq_acc >= sq_trial);
    sq_rem_nxt = sq_ge ? (sq_acc - sq_trial) : sq_acc;
    root_nxt   = (root << 1) | RW'(sq_ge);
    root_half  = root_nxt >> 1;
    kap_nxt    = (root_half > RW'(SAT_MAX)) ? SAT_MAX[W-2:0] : root_half[W-2:0];
  end

  // One restoring division step of 2^(2F) by kappa; the single dividend one-bit enters first
  always_comb begin
    kap_ext    = DRW'(kap_r);
    dv_acc     = (dv_rem << 1) | DRW'(cnt == '0);
    dv_ge      = (dv_acc >= kap_ext);
    dv_rem_nxt = dv_ge ? (dv_acc - kap_ext) : dv_acc;
    quo_nxt    = (quo << 1) | QW'(dv_ge);
    quo_ext    = MW'(quo_nxt);
    if (kap_r == '0)
      inv_nxt = SAT_MAX;
    else if (quo_ext > MW'(SAT_MAX))
      inv_nxt = SAT_MAX;
    else
      inv_nxt = quo_ext[W-1:0];
  end

  // Datapath: operand capture and the iterative sqrt/divide registers, stepped by the FSM state
  // NOTE: datapath registers carry no reset; each is written before the FSM lets it be read.
  always_ff @(posedge clk) begin
    if (ena) begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a0_r <= a0;
            a1_r <= a1;
            ch_r <= in_ch;
          end
        end
        S_SQUARE: begin
          rad     <= disc_mag;
          reg_new <= regime_new;
          sq_rem  <= '0;
          root    <= '0;
        end
        S_SQRT: begin
          rad    <= rad << 2;
          sq_rem <= sq_rem_nxt;
          root   <= root_nxt;
          kap_r  <= kap_nxt;
          dv_rem <= '0;
          quo    <= '0;
        end
        S_DIV: begin
          dv_rem <= dv_rem_nxt;
          quo    <= quo_nxt;
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered handshake, status and result outputs
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_ch      <= '0;
      kappa       <= '0;
      inv_kappa   <= '0;
      regime      <= '0;
      inv_invalid <= 1'b0;
      regime_chg  <= 1'b0;
      // NOTE: the regime table is reset on purpose: a cleared entry makes the first result on a channel report a change.
      for (int i = 0; i < CH; i++) reg_tab[i] <= '0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state    <= S_SQUARE;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_SQUARE: begin
          state <= S_SQRT;
          cnt   <= '0;
        end
        S_SQRT: begin
          if (cnt == CNTW'(W)) begin
            state <= S_DIV;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        S_DIV: begin
          if (cnt == CNTW'(QW - 1)) begin
            state          <= S_OUT;
            out_valid      <= 1'b1;
            out_ch         <= ch_r;
            kappa          <= W'(kap_r);
            inv_kappa      <= inv_nxt;
            regime         <= reg_new;
            inv_invalid    <= (kap_r == '0);
            regime_chg     <= (reg_tab[ch_r] != reg_new);
            reg_tab[ch_r]  <= reg_new;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eig_core_mc.sv
// tb_eig_core_mc: directed and randomized jobs against a behavioural model of
// the damping-regime arithmetic (exact 64-bit math, binary-search square root).
module tb_eig_core_mc;

  localparam int W  = 32;
  localparam int F  = 16;
  localparam int CH = 4;
  localparam int CW = 2;
  localparam logic [31:0] SMAX = 32'h7FFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ch;
  logic [W-1:0]  a0;
  logic [W-1:0]  a1;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ch;
  logic [W-1:0]  kappa;
  logic [W-1:0]  inv_kappa;
  logic [2:0]    regime;
  logic          inv_invalid;
  logic          regime_chg;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: last regime per channel, expected results of the current job
  logic [2:0]  tab [CH];
  logic [31:0] e_kappa;
  logic [31:0] e_inv;
  logic [2:0]  e_reg;
  logic        e_invalid;
  logic        e_chg;

  eig_core_mc #(.W(W), .F(F), .CH(CH)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ch       (in_ch),
    .a0          (a0),
    .a1          (a1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .kappa       (kappa),
    .inv_kappa   (inv_kappa),
    .regime      (regime),
    .inv_invalid (inv_invalid),
    .regime_chg  (regime_chg),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned n);
    longint unsigned lo;
    longint unsigned hi;
    longint unsigned mid;
    lo = 0;
    hi = 64'h1_0000_0000;
    while (hi - lo > 1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid <= n) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  // Expected results for one pair, straight from the arithmetic definition
  task automatic model(input int ch, input logic [31:0] x0, input logic [31:0] x1);
    longint          alpha;
    longint          beta;
    longint          disc;
    longint          k;
    longint          q;
    longint unsigned mag;
    alpha = longint'($signed(x0));
    beta  = longint'($signed(x1));
    disc  = beta * beta - alpha * 4 * 65536;
    if (disc > 0)       e_reg = 3'b100;
    else if (disc == 0) e_reg = 3'b010;
    else                e_reg = 3'b001;
    mag = (disc < 0) ? -disc : disc;
    k   = longint'(isqrt(mag)) / 2;
    if (k > 64'sd2147483647) k = 64'sd2147483647;
    e_kappa = k[31:0];
    if (k == 0) begin
      e_inv     = SMAX;
      e_invalid = 1'b1;
    end else begin
      q         = 64'sd4294967296 / k;
      e_inv     = (q > 64'sd2147483647) ? SMAX : q[31:0];
      e_invalid = 1'b0;
    end
    e_chg   = (tab[ch] != e_reg);
    tab[ch] = e_reg;
  endtask

  // One full job: offer, wait (optionally with an ena-low window), check, stall, hand off
  task automatic do_job(input int ch, input logic [31:0] x0, input logic [31:0] x1,
                        input int hold, input int ena_at, input int ena_n);
    int lat;
    model(ch, x0, x1);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_ch    = CW'(ch);
    a0       = x0;
    a1       = x1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_ch    = CW'($urandom);
    a0       = $urandom;
    a1       = $urandom;
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 400) begin
      ena = !(lat >= ena_at && lat < ena_at + ena_n);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    ena = 1'b1;
    check("out_valid", out_valid, 1);
    check("latency", lat, 68 + ena_n);
    check("kappa", kappa, e_kappa);
    check("inv_kappa", inv_kappa, e_inv);
    check("regime", regime, e_reg);
    check("inv_invalid", inv_invalid, e_invalid);
    check("regime_chg", regime_chg, e_chg);
    check("out_ch", out_ch, ch);
    check("busy_out", busy, 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_kappa", kappa, e_kappa);
      check("hold_inv", inv_kappa, e_inv);
      check("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);
    check("post_busy", busy, 0);
    check("post_kappa", kappa, e_kappa);
    check("post_regime", regime, e_reg);
  endtask

  initial begin
    int          seen;
    int          ch;
    int          mode;
    int          m;
    logic [31:0] x0;
    logic [31:0] x1;

    rst       = 1'b1;
    ena       = 1'b1;
    in_valid  = 1'b0;
    in_ch     = '0;
    a0        = '0;
    a1        = '0;
    out_ready = 1'b0;
    for (int i = 0; i < CH; i++) tab[i] = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_kappa", kappa, 0);
    check("rst_inv_kappa", inv_kappa, 0);
    check("rst_regime", regime, 0);
    check("rst_inv_invalid", inv_invalid, 0);
    check("rst_regime_chg", regime_chg, 0);
    check("rst_out_ch", out_ch, 0);

    // Critical: kappa zero, inverse saturated and flagged
    do_job(0, 32'h0001_0000, 32'h0002_0000, 0, 0, 0);
    check("r37_regime", regime, 3'b010);
    check("r37_kappa", kappa, 32'h0000_0000);
    check("r37_inv", inv_kappa, 32'h7FFF_FFFF);
    check("r37_invalid", inv_invalid, 1);

    // Overdamped
    do_job(1, 32'h0001_0000, 32'h0006_0000, 0, 0, 0);
    check("r38_regime", regime, 3'b100);
    check("r38_kappa", kappa, 32'h0002_D413);
    check("r38_inv", inv_kappa, 32'h0000_5A82);

    // Underdamped
    do_job(3, 32'h0005_0000, 32'h0002_0000, 0, 0, 0);
    check("r39_regime", regime, 3'b001);
    check("r39_kappa", kappa, 32'h0002_0000);
    check("r39_inv", inv_kappa, 32'h0000_8000);
    check("r39_invalid", inv_invalid, 0);

    // Boundaries: one-LSB discriminant, inverse saturation edges, extreme operands
    do_job(2, 32'h0000_0000, 32'h0000_0001, 0, 0, 0);
    check("b_lsb_invalid", inv_invalid, 1);
    check("b_lsb_regime", regime, 3'b100);
    do_job(2, 32'h0000_0000, 32'h0000_0004, 0, 0, 0);
    check("b_k2_inv", inv_kappa, 32'h7FFF_FFFF);
    check("b_k2_invalid", inv_invalid, 0);
    do_job(2, 32'h0000_0000, 32'h0000_0006, 0, 0, 0);
    check("b_k3_inv", inv_kappa, 32'h5555_5555);
    do_job(1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
    do_job(0, 32'h7FFF_FFFF, 32'h0000_0000, 0, 0, 0);

    // Reset during SQRT (asserted with ena low) aborts the job silently
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = 2'd0;
    a0       = 32'h0001_0000;
    a1       = 32'h0006_0000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 1);
    rst = 1'b1;
    ena = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ena = 1'b1;
    for (int i = 0; i < CH; i++) tab[i] = 3'b000;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy_low", busy, 0);
    check("abort_kappa", kappa, 0);
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    check("abort_silent", seen, 0);
    do_job(0, 32'h0005_0000, 32'h0002_0000, 0, 0, 0);
    check("r42_chg", regime_chg, 1);

    // Regime-change sequence on fresh channels 2 and 1
    do_job(2, 32'h0005_0000, 32'h0002_0000, 0, 0, 0);
    check("r40_chg_a", regime_chg, 1);
    do_job(2, 32'h0001_0000, 32'h0006_0000, 0, 0, 0);
    check("r40_chg_b", regime_chg, 1);
    do_job(2, 32'h0001_0000, 32'h0006_0000, 0, 0, 0);
    check("r40_chg_c", regime_chg, 0);
    do_job(1, 32'h0005_0000, 32'h0002_0000, 0, 0, 0);
    check("r40_chg_d", regime_chg, 1);

    // Consumer stall of 10 cycles, then ena low for 5 cycles inside DIV
    do_job(3, 32'h0001_0000, 32'h0006_0000, 10, 0, 0);
    do_job(3, 32'h0005_0000, 32'h0002_0000, 0, 45, 5);

    // Randomized jobs across all regimes and channels
    for (int j = 0; j < 24; j++) begin
      ch   = $urandom_range(0, CH - 1);
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          x0 = $urandom;
          x1 = $urandom;
        end
        1: begin
          x0 = $urandom & 32'h001F_FFFF;
          x1 = $urandom & 32'h001F_FFFF;
          if ($urandom_range(0, 1) == 1) x0 = -x0;
          if ($urandom_range(0, 1) == 1) x1 = -x1;
        end
        2: begin
          m  = $urandom_range(0, 255);
          x1 = m * 512;
          x0 = m * m;
          if ($urandom_range(0, 1) == 1) x1 = -x1;
        end
        default: begin
          x0 = $urandom & 32'h7FFF_FFFF;
          x1 = $urandom & 32'h0000_FFFF;
        end
      endcase
      do_job(ch, x0, x1, $urandom_range(0, 2), $urandom_range(2, 60), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
